// File: rtl/stack_frame_ctrl.sv
// Call-frame sequencer in front of one SuperStack. Owns the stack's underflow limit
// (the frame base), keeps a small stack of saved frame bases, runs CALL/RET/DROPN
// itself and forwards core stack ops when idle.
module stack_frame_ctrl #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEPTH       = 1,
    parameter int unsigned FRAMES_LOG2 = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    input  logic [1:0]       cmd_i,
    input  logic [DEPTH:0]   cmd_arg_i,
    output logic             cmd_ready_o,
    output logic             done_o,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    input  logic [1:0]       core_op_i,
    input  logic [WIDTH-1:0] core_data_i,
    output logic             stk_reset_o,
    output logic [1:0]       stk_op_o,
    output logic [WIDTH-1:0] stk_data_o,
    output logic [DEPTH:0]   stk_underflow_limit_o,
    input  logic [WIDTH-1:0] stk_tos_i,
    input  logic [2:0]       stk_status_i
);

    localparam int unsigned NumFrames = 2 ** FRAMES_LOG2;
    localparam logic [DEPTH:0] Cap = {1'b1, {DEPTH{1'b0}}};
    localparam logic [DEPTH:0] ArgOne = {{DEPTH{1'b0}}, 1'b1};
    localparam logic [FRAMES_LOG2:0] FramesFull = {1'b1, {FRAMES_LOG2{1'b0}}};

    localparam logic [1:0] OpNone    = 2'd0;
    localparam logic [1:0] OpPush    = 2'd1;
    localparam logic [1:0] OpPop     = 2'd2;

    localparam logic [1:0] CmdCall   = 2'd1;
    localparam logic [1:0] CmdRet    = 2'd2;
    localparam logic [1:0] CmdDropn  = 2'd3;
    localparam logic [1:0] CmdNop    = 2'd0;

    localparam logic [1:0] ErrArgs     = 2'd0;
    localparam logic [1:0] ErrFrameOvf = 2'd1;
    localparam logic [1:0] ErrFrameUnf = 2'd2;

    // StUnwind pops down to the frame base, then restores the saved base in the
    // cycle where nothing is left to pop.
    typedef enum logic [2:0] {
        StIdle,
        StPopRes,
        StUnwind,
        StPushRes,
        StDrop
    } state_e;

    state_e                   state_q;
    logic                     stk_reset_q;
    logic [DEPTH:0]           sp_q, sp_d;
    logic [DEPTH:0]           limit_q;
    logic [FRAMES_LOG2:0]     fdepth_q;
    logic [DEPTH:0]           frame_q [NumFrames];
    logic [WIDTH-1:0]         result_q;
    logic                     ret_res_q;
    logic [DEPTH:0]           cnt_q;
    logic                     done_q;
    logic                     err_q;
    logic [1:0]               err_code_q;

    logic [DEPTH:0]           used;
    logic [FRAMES_LOG2-1:0]   fidx;
    logic [FRAMES_LOG2-1:0]   fidx_top;
    logic                     accept;
    logic                     chk_err;
    logic [1:0]               chk_code;
    logic                     unused_status;

    // Status is only there for the core to observe; sequencing never uses it.
    assign unused_status = ^stk_status_i;

    assign used     = sp_q - limit_q;
    assign fidx     = fdepth_q[FRAMES_LOG2-1:0];
    assign fidx_top = fidx - 1'b1;

    assign cmd_ready_o           = (state_q == StIdle) && !stk_reset_q;
    assign accept                = cmd_valid_i && cmd_ready_o && (cmd_i != CmdNop);
    assign done_o                = done_q;
    assign err_o                 = err_q;
    assign err_code_o            = err_code_q;
    assign stk_reset_o           = stk_reset_q;
    assign stk_underflow_limit_o = limit_q;

    // Stack op mux: core ops pass through in IDLE, otherwise the sequencer drives.
    always_comb begin
        stk_op_o   = OpNone;
        stk_data_o = '0;
        case (state_q)
            StIdle: begin
                if (!stk_reset_q) begin
                    stk_op_o   = core_op_i;
                    stk_data_o = core_data_i;
                end
            end
            StPopRes: stk_op_o = OpPop;
            StUnwind: begin
                if (used != '0) begin
                    stk_op_o = OpPop;
                end
            end
            StPushRes: begin
                stk_op_o   = OpPush;
                stk_data_o = result_q;
            end
            StDrop: stk_op_o = OpPop;
            default: ;
        endcase
    end

    // Mirror of the stack pointer, following the same saturation rules as the stack.
    always_comb begin
        sp_d = sp_q;
        case (stk_op_o)
            OpPush: if (sp_q < Cap) sp_d = sp_q + 1'b1;
            OpPop:  if (sp_q > limit_q) sp_d = sp_q - 1'b1;
            default: ;
        endcase
    end

    // Acceptance checks, evaluated against the pre-update sp.
    always_comb begin
        chk_err  = 1'b0;
        chk_code = ErrArgs;
        case (cmd_i)
            CmdCall: begin
                if (used < cmd_arg_i) begin
                    chk_err = 1'b1;
                end else if (fdepth_q == FramesFull) begin
                    chk_err  = 1'b1;
                    chk_code = ErrFrameOvf;
                end
            end
            CmdRet: begin
                if (fdepth_q == '0) begin
                    chk_err  = 1'b1;
                    chk_code = ErrFrameUnf;
                end else if ((cmd_arg_i > ArgOne) || (used < cmd_arg_i)) begin
                    chk_err = 1'b1;
                end
            end
            CmdDropn: begin
                if (used < cmd_arg_i) begin
                    chk_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Frame sequencer with registered status pulses and frame bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            stk_reset_q <= 1'b1;
            sp_q        <= '0;
            limit_q     <= '0;
            fdepth_q    <= '0;
            result_q    <= '0;
            ret_res_q   <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ErrArgs;
            for (int i = 0; i < NumFrames; i++) begin
                frame_q[i] <= '0;
            end
        end else begin
            stk_reset_q <= 1'b0;
            sp_q        <= sp_d;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ErrArgs;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (chk_err) begin
                            err_q      <= 1'b1;
                            err_code_q <= chk_code;
                        end else begin
                            case (cmd_i)
                                CmdCall: begin
                                    frame_q[fidx] <= limit_q;
                                    fdepth_q      <= fdepth_q + 1'b1;
                                    limit_q       <= sp_q - cmd_arg_i;
                                    done_q        <= 1'b1;
                                end
                                CmdRet: begin
                                    ret_res_q <= cmd_arg_i[0];
                                    state_q   <= cmd_arg_i[0] ? StPopRes : StUnwind;
                                end
                                CmdDropn: begin
                                    if (cmd_arg_i == '0) begin
                                        done_q <= 1'b1;
                                    end else begin
                                        cnt_q   <= cmd_arg_i;
                                        state_q <= StDrop;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                StPopRes: begin
                    result_q <= stk_tos_i;
                    state_q  <= StUnwind;
                end
                StUnwind: begin
                    if (used == '0) begin
                        limit_q  <= frame_q[fidx_top];
                        fdepth_q <= fdepth_q - 1'b1;
                        if (ret_res_q) begin
                            state_q <= StPushRes;
                        end else begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StPushRes: begin
                    state_q <= StIdle;
                    done_q  <= 1'b1;
                end
                StDrop: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == ArgOne) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_frame_ctrl.sv
// Bench for stack_frame_ctrl: a small SuperStack model sits on the stack side,
// a per-cycle vector table drives the core side, plus hand-written reset sequences.
module tb_stack_frame_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 2;
    localparam int unsigned FL = 1;

    localparam logic [1:0] N  = 2'd0;
    localparam logic [1:0] PU = 2'd1;
    localparam logic [1:0] PO = 2'd2;
    localparam logic [1:0] RP = 2'd3;
    localparam logic [1:0] CALL = 2'd1;
    localparam logic [1:0] RET  = 2'd2;
    localparam logic [1:0] DROP = 2'd3;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         cmd_valid;
    logic [1:0]   cmd;
    logic [D:0]   cmd_arg;
    logic         cmd_ready;
    logic         done;
    logic         err;
    logic [1:0]   err_code;
    logic [1:0]   core_op;
    logic [W-1:0] core_data;
    logic         stk_reset;
    logic [1:0]   stk_op;
    logic [W-1:0] stk_data;
    logic [D:0]   stk_lim;
    logic [W-1:0] stk_tos;
    logic [2:0]   stk_status;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    stack_frame_ctrl #(
        .WIDTH       (W),
        .DEPTH       (D),
        .FRAMES_LOG2 (FL)
    ) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .cmd_valid_i           (cmd_valid),
        .cmd_i                 (cmd),
        .cmd_arg_i             (cmd_arg),
        .cmd_ready_o           (cmd_ready),
        .done_o                (done),
        .err_o                 (err),
        .err_code_o            (err_code),
        .core_op_i             (core_op),
        .core_data_i           (core_data),
        .stk_reset_o           (stk_reset),
        .stk_op_o              (stk_op),
        .stk_data_o            (stk_data),
        .stk_underflow_limit_o (stk_lim),
        .stk_tos_i             (stk_tos),
        .stk_status_i          (stk_status)
    );

    // Behavioural SuperStack: CAP=4, pops blocked at the underflow limit.
    logic [W-1:0] mem [4];
    int           msp = 0;
    logic [1:0]   top_idx;

    always @(posedge clk_i) begin
        if (stk_reset) begin
            msp <= 0;
            for (int k = 0; k < 4; k++) mem[k] <= '0;
        end else begin
            case (stk_op)
                PU: if (msp < 4) begin
                    mem[2'(msp)] <= stk_data;
                    msp <= msp + 1;
                end
                PO: if (msp > int'(stk_lim)) msp <= msp - 1;
                RP: if (msp > 0) mem[2'(msp - 1)] <= stk_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        top_idx = 2'(msp - 1);
        stk_tos = (msp > 0) ? mem[top_idx] : '0;
    end
    assign stk_status = 3'd0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] data;
        logic         cv;
        logic [1:0]   cmd;
        logic [D:0]   arg;
        logic         rdy;
        logic         dn;
        logic         er;
        logic [1:0]   code;
        logic [1:0]   sop;
        logic [W-1:0] sdata;
        logic [D:0]   lim;
        logic [W-1:0] tos;
        int           msp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic [1:0] op, input logic [W-1:0] data, input logic cv,
                               input logic [1:0] c, input logic [D:0] arg, input logic rdy,
                               input logic dn, input logic er, input logic [1:0] code,
                               input logic [1:0] sop, input logic [W-1:0] sdata,
                               input logic [D:0] lim, input logic [W-1:0] tos, input int sp);
        vec_t r;
        r.op = op; r.data = data; r.cv = cv; r.cmd = c; r.arg = arg;
        r.rdy = rdy; r.dn = dn; r.er = er; r.code = code; r.sop = sop;
        r.sdata = sdata; r.lim = lim; r.tos = tos; r.msp = sp;
        return r;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (row %0d): got %0h, expected %0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [W-1:0] data, input logic cv,
                         input logic [1:0] c, input logic [D:0] arg);
        core_op = op; core_data = data; cmd_valid = cv; cmd = c; cmd_arg = arg;
    endtask

    bit seen_pulse;

    initial begin
        // Columns: op, data, cmd_valid, cmd, arg | ready, done, err, code, stk_op, stk_data,
        //          limit, tos, sp -- all as seen during the cycle the inputs are applied.
        vecs.push_back(v(PU, 8'h11, 0, 0,    0, 1, 0, 0, 0, PU, 8'h11, 0, 8'h00, 0));
        vecs.push_back(v(PU, 8'h22, 0, 0,    0, 1, 0, 0, 0, PU, 8'h22, 0, 8'h11, 1));
        vecs.push_back(v(PU, 8'h33, 0, 0,    0, 1, 0, 0, 0, PU, 8'h33, 0, 8'h22, 2));
        vecs.push_back(v(N,  8'h00, 1, CALL, 1, 1, 0, 0, 0, N,  8'h00, 0, 8'h33, 3));
        vecs.push_back(v(N,  8'h00, 0, 0,    0, 1, 1, 0, 0, N,  8'h00, 2, 8'h33, 3));
        vecs.push_back(v(PO, 8'h00, 0, 0,    0, 1, 0, 0, 0, PO, 8'h00, 2, 8'h33, 3));
        vecs.push_back(v(PO, 8'h00, 0, 0,    0, 1, 0, 0, 0, PO, 8'h00, 2, 8'h22, 2));
        vecs.push_back(v(PU, 8'h33, 0, 0,    0, 1, 0, 0, 0, PU, 8'h33, 2, 8'h22, 2));
        vecs.push_back(v(PU, 8'h44, 0, 0,    0, 1, 0, 0, 0, PU, 8'h44, 2, 8'h33, 3));
        vecs.push_back(v(N,  8'h00, 1, RET,  1, 1, 0, 0, 0, N,  8'h00, 2, 8'h44, 4));
        vecs.push_back(v(N,  8'h00, 0, 0,    0, 0, 0, 0, 0, PO, 8'h00, 2, 8'h44, 4));
        vecs.push_back(v(PU, 8'h99, 0, 0,    0, 0, 0, 0, 0, PO, 8'h00, 2, 8'h33, 3));
        vecs.push_back(v(N,  8'h00, 0, 0,    0, 0, 0, 0, 0, N,  8'h00, 2, 8'h22, 2));
        vecs.push_back(v(N,  8'h00, 0, 0,    0, 0, 0, 0, 0, PU, 8'h44, 0, 8'h22, 2));
        vecs.push_back(v(N,  8'h00, 0, 0,    0, 1, 1, 0, 0, N,  8'h00, 0, 8'h44, 3));
        vecs.push_back(v(N,  8'h00, 1, RET,  0, 1, 0, 0, 0, N,  8'h00, 0, 8'h44, 3));
        vecs.push_back(v(N,  8'h00, 0, 0,    0, 1, 0, 1, 2, N,  8'h00, 0, 8'h44, 3));
        vecs.push_back(v(N,  8'h00, 0, 0,    0, 1, 0, 0, 0, N,  8'h00, 0, 8'h44, 3));
        vecs.push_back(v(N,  8'h00, 1, CALL, 0, 1, 0, 0, 0, N,  8'h00, 0, 8'h44, 3));
        vecs.push_back(v(N,  8'h00, 1, CALL, 0, 1, 1, 0, 0, N,  8'h00, 3, 8'h44, 3));
        vecs.push_back(v(N,  8'h00, 1, CALL, 0, 1, 1, 0, 0, N,  8'h00, 3, 8'h44, 3));
        vecs.push_back(v(N,  8'h00, 0, 0,    0, 1, 0, 1, 1, N,  8'h00, 3, 8'h44, 3));
        vecs.push_back(v(N,  8'h00, 1, RET,  0, 1, 0, 0, 0, N,  8'h00, 3, 8'h44, 3));
        vecs.push_back(v(N,  8'h00, 0, 0,    0, 0, 0, 0, 0, N,  8'h00, 3, 8'h44, 3));
        vecs.push_back(v(N,  8'h00, 0, 0,    0, 1, 1, 0, 0, N,  8'h00, 3, 8'h44, 3));
        vecs.push_back(v(N,  8'h00, 1, RET,  0, 1, 0, 0, 0, N,  8'h00, 3, 8'h44, 3));
        vecs.push_back(v(N,  8'h00, 0, 0,    0, 0, 0, 0, 0, N,  8'h00, 3, 8'h44, 3));
        vecs.push_back(v(N,  8'h00, 0, 0,    0, 1, 1, 0, 0, N,  8'h00, 0, 8'h44, 3));
        vecs.push_back(v(N,  8'h00, 1, CALL, 5, 1, 0, 0, 0, N,  8'h00, 0, 8'h44, 3));
        vecs.push_back(v(N,  8'h00, 0, 0,    0, 1, 0, 1, 0, N,  8'h00, 0, 8'h44, 3));
        vecs.push_back(v(N,  8'h00, 1, DROP, 2, 1, 0, 0, 0, N,  8'h00, 0, 8'h44, 3));
        vecs.push_back(v(N,  8'h00, 0, 0,    0, 0, 0, 0, 0, PO, 8'h00, 0, 8'h44, 3));
        vecs.push_back(v(N,  8'h00, 0, 0,    0, 0, 0, 0, 0, PO, 8'h00, 0, 8'h22, 2));
        vecs.push_back(v(N,  8'h00, 0, 0,    0, 1, 1, 0, 0, N,  8'h00, 0, 8'h11, 1));
        vecs.push_back(v(N,  8'h00, 1, DROP, 0, 1, 0, 0, 0, N,  8'h00, 0, 8'h11, 1));
        vecs.push_back(v(N,  8'h00, 0, 0,    0, 1, 1, 0, 0, N,  8'h00, 0, 8'h11, 1));
        vecs.push_back(v(N,  8'h00, 1, DROP, 2, 1, 0, 0, 0, N,  8'h00, 0, 8'h11, 1));
        vecs.push_back(v(N,  8'h00, 0, 0,    0, 1, 0, 1, 0, N,  8'h00, 0, 8'h11, 1));
        vecs.push_back(v(RP, 8'h55, 0, 0,    0, 1, 0, 0, 0, RP, 8'h55, 0, 8'h11, 1));
        vecs.push_back(v(N,  8'h00, 0, 0,    0, 1, 0, 0, 0, N,  8'h00, 0, 8'h55, 1));
        vecs.push_back(v(PU, 8'h66, 1, CALL, 0, 1, 0, 0, 0, PU, 8'h66, 0, 8'h55, 1));
        vecs.push_back(v(N,  8'h00, 0, 0,    0, 1, 1, 0, 0, N,  8'h00, 1, 8'h66, 2));
        vecs.push_back(v(PU, 8'h77, 0, 0,    0, 1, 0, 0, 0, PU, 8'h77, 1, 8'h66, 2));
        vecs.push_back(v(N,  8'h00, 1, RET,  0, 1, 0, 0, 0, N,  8'h00, 1, 8'h77, 3));
        vecs.push_back(v(N,  8'h00, 0, 0,    0, 0, 0, 0, 0, PO, 8'h00, 1, 8'h77, 3));

        // Power-on reset, with a core PUSH held on the inputs to confirm it is gated.
        rst_ni = 1'b0;
        drive(PU, 8'hAA, 1'b1, CALL, 0);
        #12;
        check("reset_stk_reset", 0, 32'(stk_reset), 32'd1);
        check("reset_cmd_ready", 0, 32'(cmd_ready), 32'd0);
        check("reset_stk_op",    0, 32'(stk_op),    32'd0);
        check("reset_stk_data",  0, 32'(stk_data),  32'd0);
        check("reset_done_err",  0, 32'({done, err, err_code}), 32'd0);
        check("reset_limit",     0, 32'(stk_lim),   32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        drive(N, 8'h00, 1'b0, 0, 0);
        #1;
        check("release_stk_reset_held", 0, 32'(stk_reset), 32'd1);
        @(posedge clk_i); #1;
        check("release_stk_reset_drop", 0, 32'(stk_reset), 32'd0);
        check("release_cmd_ready",      0, 32'(cmd_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].op, vecs[i].data, vecs[i].cv, vecs[i].cmd, vecs[i].arg);
            #1;
            check("cmd_ready", i + 1, 32'(cmd_ready), 32'(vecs[i].rdy));
            check("done",      i + 1, 32'(done),      32'(vecs[i].dn));
            check("err",       i + 1, 32'(err),       32'(vecs[i].er));
            if (vecs[i].er) check("err_code", i + 1, 32'(err_code), 32'(vecs[i].code));
            check("stk_op",    i + 1, 32'(stk_op),    32'(vecs[i].sop));
            check("stk_data",  i + 1, 32'(stk_data),  32'(vecs[i].sdata));
            check("limit",     i + 1, 32'(stk_lim),   32'(vecs[i].lim));
            check("tos",       i + 1, 32'(stk_tos),   32'(vecs[i].tos));
            check("sp",        i + 1, 32'(msp),       32'(vecs[i].msp));
            check("stk_reset", i + 1, 32'(stk_reset), 32'd0);
            @(posedge clk_i); #1;
        end

        // RET 0 from sp=3, limit=1 is now on its second unwind pop; reset it mid-flight.
        drive(N, 8'h00, 1'b0, 0, 0);
        #1;
        check("unwind_still_popping", 99, 32'(stk_op), 32'(PO));
        rst_ni = 1'b0;
        #1;
        check("abort_stk_reset", 99, 32'(stk_reset), 32'd1);
        check("abort_cmd_ready", 99, 32'(cmd_ready), 32'd0);
        check("abort_stk_op",    99, 32'(stk_op),    32'd0);
        check("abort_limit",     99, 32'(stk_lim),   32'd0);
        check("abort_done_err",  99, 32'({done, err}), 32'd0);
        seen_pulse = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk_i); #1;
            if (done || err) seen_pulse = 1'b1;
        end
        check("abort_no_done", 99, 32'(seen_pulse), 32'd0);
        check("after_abort_ready", 99, 32'(cmd_ready), 32'd1);
        check("after_abort_limit", 99, 32'(stk_lim),   32'd0);
        check("after_abort_sp",    99, 32'(msp),       32'd0);

        // Fresh frame after the abort: frame storage must be empty again.
        drive(N, 8'h00, 1'b1, RET, 0);
        @(posedge clk_i); #1;
        drive(N, 8'h00, 1'b0, 0, 0);
        #1;
        check("after_abort_ret_unf", 100, 32'({err, err_code}), 32'({1'b1, 2'd2}));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stack_frame_ctrl.md
Name: stack_frame_ctrl

Overview:
- Call-frame sequencer sitting between the core and one SuperStack instance.
- Owns the stack's `underflow_limit`, which acts as the frame base, and keeps a small internal stack of saved frame bases.
- Executes multi-cycle frame commands (CALL, RET, DROPN) by driving stack ops itself.
- When idle, forwards core PUSH/POP/REPLACE ops straight through to the stack.

Parameters:
- WIDTH, 8: data width; matches the attached SuperStack.
- DEPTH, 1: SuperStack DEPTH; capacity CAP = 2^DEPTH entries; index/limit width DEPTH+1.
- FRAMES_LOG2, 2: saved-frame storage holds 2^FRAMES_LOG2 entries.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- cmd_valid  in  1  frame command request.
- cmd  in  2  0=NOP, 1=CALL, 2=RET, 3=DROPN.
- cmd_arg  in  DEPTH+1  CALL: argument count n. RET: result count r (0 or 1). DROPN: count n.
- cmd_ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse when a command completes successfully.
- err  out  1  one-cycle pulse when a command is rejected.
- err_code  out  2  valid with err: 0=ARGS, 1=FRAME_OVF, 2=FRAME_UNF.
- core_op  in  2  stack op from core (`stack.vh` encoding: NONE/PUSH/POP/REPLACE).
- core_data  in  WIDTH  data for core_op.
- stk_reset  out  1  active-high synchronous reset to the SuperStack.
- stk_op  out  2  op to the SuperStack.
- stk_data  out  WIDTH  data to the SuperStack.
- stk_underflow_limit  out  DEPTH+1  current frame base.
- stk_tos  in  WIDTH  SuperStack top of stack.
- stk_status  in  3  SuperStack status; used for pass-through visibility only, not for sequencing.

Behaviour:
- Reset values (async on reset low):
  - state=IDLE, sp=0, limit=0, fdepth=0, result register cleared.
  - stk_reset=1, stk_op=NONE, stk_data=0.
  - done=0, err=0, err_code=0, cmd_ready=0 while reset is asserted.
  - stk_reset drops to 0 on the first clock edge after reset release.
  - Reset mid-command aborts it with no done and no err.
- sp (absolute stack index, mirrored internally):
  - Updated on every edge where a PUSH or POP is issued on stk_op.
  - A core PUSH increments sp only if sp<CAP.
  - A core POP decrements sp only if sp>limit.
  - REPLACE and NONE leave sp unchanged.
- IDLE:
  - stk_op=core_op, stk_data=core_data.
  - A command is accepted on an edge with cmd_valid&cmd_ready; cmd_valid with NOP is ignored.
  - Checks are evaluated at acceptance. A failing command pulses err the next cycle, changes no state, and stays in IDLE.
- While not IDLE:
  - core_op is ignored and stk_op is driven by the FSM.
  - The core must hold off while cmd_ready is low; its ops are not queued.
- CALL n:
  - Error ARGS if sp-limit<n.
  - Error FRAME_OVF if fdepth=2^FRAMES_LOG2.
  - Otherwise, single cycle: save limit at frame[fdepth], fdepth+1, limit<=sp-n, done pulse next cycle, no stack op.
- RET r:
  - Error FRAME_UNF if fdepth=0.
  - Error ARGS if r>1 or sp-limit<r.
  - States, in order:
    - POPRES (only if r=1): result<=stk_tos; issue POP.
    - UNWIND: issue POP each cycle while sp>limit.
    - RESTORE: limit<=frame[fdepth-1], fdepth-1, no op.
    - PUSHRES (only if r=1): issue PUSH result.
    - DONE: done pulse, return to IDLE.
  - Busy cycles = (sp-limit) + 2 + r, counting from acceptance to the done pulse inclusive.
- DROPN n:
  - Error ARGS if sp-limit<n.
  - Otherwise issue POP for n cycles, then done; n=0 gives done after one cycle.
- Ordering: stk_underflow_limit changes on the same edge as the state change. The stack sees the new limit from the next cycle onward.
- Simultaneous core_op and command acceptance in IDLE: the core op is forwarded on that cycle. Checks use the sp value before that op's update.
- Width rules: all sp/limit arithmetic is unsigned DEPTH+1 bits; comparisons use the subtraction sp-limit, which is never negative by invariant limit<=sp.

Test Plan:
- After reset (DEPTH=2, FRAMES_LOG2=1): stk_reset=1 for one cycle, stk_underflow_limit=0, cmd_ready=1. Core PUSH 0x11, 0x22, 0x33 -> tos=0x33, sp=3, status NONE.
- CALL n=1 -> done after 1 cycle, stk_underflow_limit=2, stack status NONE. Core POP -> status EMPTY. Further POP -> stack UNDERFLOW, sp stays 2.
- From sp=3, limit=2: PUSH 0x44, then RET r=1 -> cmd_ready low for 4 cycles (POPRES, UNWIND, RESTORE, PUSHRES), done pulse. Then limit=0, sp=3, tos=0x44; entries below are 0x11, 0x22.
- RET with fdepth=0 -> err=1, err_code=2, no stk_op issued, sp/limit unchanged.
- Two CALLs then a third CALL -> err_code=1. CALL n=5 with sp=3 -> err_code=0.
- DROPN n=2 at sp=3, limit=0 -> two POPs, then done. tos=0x11, sp=1. Assert async reset during a RET unwind -> outputs return to reset values immediately, with no done.
